// File: rtl/pipelined_adder_pkg.sv
// Shared constants for the pipelined add/subtract datapath.
// Mode encodings and default geometry reused by the ALU.
package pipelined_adder_pkg;

    localparam logic ADD_OP = 1'b0;
    localparam logic SUB_OP = 1'b1;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit slice adder with carry in and out.
// One instance per pipeline stage; holds no state.
module adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int SW = DEFAULT_WIDTH / DEFAULT_STAGES
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract, one slice per stage.
// Carry rides between stages; stall is global via valid/ready.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] val_1,
    input  logic [WIDTH-1:0] val_2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    logic                          adv;
    logic [WIDTH-1:0]              b_in;

    logic [STAGES-1:0]             vld_q;
    logic [STAGES-1:0]             cy_q;
    logic [STAGES-1:0][WIDTH-1:0]  a_q;
    logic [STAGES-1:0][WIDTH-1:0]  b_q;
    logic [STAGES-1:0][WIDTH-1:0]  sum_q;
    logic [STAGES-1:0][WIDTH-1:0]  sum_n;

    logic [STAGES-1:0][SW-1:0]     slc_a;
    logic [STAGES-1:0][SW-1:0]     slc_b;
    logic [STAGES-1:0][SW-1:0]     slc_s;
    logic [STAGES-1:0]             slc_ci;
    logic [STAGES-1:0]             slc_co;

    logic                          unused_tail;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_in     = (sub == SUB_OP) ? ~val_2 : val_2;

    for (genvar s = 0; s < STAGES; s++) begin : g_slice
        adder_slice #(.SW(SW)) u_slice (
            .a    (slc_a[s]),
            .b    (slc_b[s]),
            .cin  (slc_ci[s]),
            .sum  (slc_s[s]),
            .cout (slc_co[s])
        );
    end

    // Slice operands: stage 0 from the ports, later stages from delayed operands
    always_comb begin
        slc_a  = '0;
        slc_b  = '0;
        slc_ci = '0;
        slc_a[0]  = val_1[SW-1:0];
        slc_b[0]  = b_in[SW-1:0];
        slc_ci[0] = (sub == SUB_OP);
        for (int s = 1; s < STAGES; s++) begin
            slc_a[s]  = a_q[s-1][s*SW +: SW];
            slc_b[s]  = b_q[s-1][s*SW +: SW];
            slc_ci[s] = cy_q[s-1];
        end
    end

    // Merge each new slice sum into the partial result passed down the pipe
    always_comb begin
        sum_n = '0;
        sum_n[0][SW-1:0] = slc_s[0];
        for (int s = 1; s < STAGES; s++) begin
            sum_n[s] = sum_q[s-1];
            sum_n[s][s*SW +: SW] = slc_s[s];
        end
    end

    // Whole pipeline shifts together when the output side can advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
        end else if (adv) begin
            vld_q[0] <= in_valid;
            a_q[0]   <= val_1;
            b_q[0]   <= b_in;
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
                a_q[s]   <= a_q[s-1];
                b_q[s]   <= b_q[s-1];
            end
            sum_q <= sum_n;
            cy_q  <= slc_co;
        end
    end

    assign out_valid = vld_q[LAST];
    assign out       = sum_q[LAST];
    assign carry_out = cy_q[LAST];
    assign overflow  = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                    && (out[WIDTH-1] != a_q[LAST][WIDTH-1]);

    // Only the sign bits of the final stage operands feed the flags
    assign unused_tail = ^{a_q[LAST][WIDTH-2:0], b_q[LAST][WIDTH-2:0]};

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined successor to the single-cycle combinational adder, for the multi-cycle and pipelined datapath variants. The block splits a WIDTH-bit add/subtract into STAGES equal slices, one slice per pipeline stage, with the carry registered between stages. It has a valid/ready handshake on both sides, so it can sit between the decode/operand stage and writeback and absorb backpressure. It adds subtract mode and carry/overflow flags, which the combinational adder does not have.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages and slices; 1 <= STAGES <= WIDTH; slice width SW = WIDTH/STAGES.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts a beat this cycle
val_1  in  WIDTH  operand A
val_2  in  WIDTH  operand B
sub  in  1  0 = A+B, 1 = A-B
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result this cycle
out  out  WIDTH  result, modulo 2^WIDTH
carry_out  out  1  carry out of the MSB; in sub mode 1 = no borrow
overflow  out  1  signed two's-complement overflow

Behaviour:
- Reset: clk and rst_n only; rst_n is asynchronous and active-low. While rst_n=0, every stage valid bit, out_valid, out, carry_out and overflow are 0. in_ready is 1 once rst_n=1.
- Reset mid-operation: all in-flight beats are discarded. No result for them ever appears.
- Advance condition: adv = !out_valid || out_ready. The whole pipeline shifts only when adv=1; when adv=0, every stage register holds.
- in_ready = adv, combinational. Accept occurs when in_valid && in_ready.
- Stage 0 on accept:
  - Latch B' = sub ? ~val_2 : val_2, and cin = sub.
  - Compute slice 0 as A[SW-1:0] + B'[SW-1:0] + cin.
  - Register the sum slice, the slice carry, the unused upper operand slices, the stage valid bit, and the sign bits A[WIDTH-1] and B'[WIDTH-1].
- Stage k (k >= 1): add slice k of the delayed operands plus the registered carry from stage k-1. Already-computed lower result slices pass through unchanged. The stage valid bit follows its predecessor.
- Final stage:
  - out = concatenated slices.
  - carry_out = carry from slice STAGES-1.
  - overflow = (A_msb == B'_msb) && (out[WIDTH-1] != A_msb).
  - out_valid = final stage valid bit.
- Latency: a beat accepted at edge N is presented with out_valid=1 after edge N+STAGES-1, when unstalled. Throughput is 1 beat/cycle when out_ready stays high.
- STAGES=1 degenerates to a registered full-width adder with latency 1.
- Bubbles: an idle input cycle inserts a stage with valid=0. Bubbles are not squeezed out; the stall is global.
- Simultaneous accept and output handshake in the same cycle is legal. No beat is lost or duplicated.
- Stall: out and flags are stable while out_valid=1 && out_ready=0.
- Width rules: no sign extension. The final carry is never folded back into out.
- Illegal parameters (WIDTH % STAGES != 0) stop elaboration via a generate-time error.

Decomposition:
- Shared defines include: op-mode constants ADD_OP=1'b0 and SUB_OP=1'b1, plus the default WIDTH and STAGES constants reused by the ALU.
- One sub-module: adder_slice. It is a combinational SW-bit adder with inputs a, b, cin and outputs sum, cout. It is instantiated STAGES times via generate; all registers stay in pipelined_adder.

Test Plan:
- Basic add (WIDTH=32, STAGES=4): val_1=5, val_2=9, sub=0, one beat, out_ready=1 -> after 4 edges, out_valid=1, out=14, carry_out=0, overflow=0.
- Streaming: back-to-back beats (0x11,0x22), (0xFFFFFFFF,1), (0x7FFFFFFF,1) on consecutive cycles -> 0x33 c0 v0, then 0x00000000 c1 v0, then 0x80000000 c0 v1 on three consecutive cycles.
- Subtract: 5-9, sub=1 -> out=0xFFFFFFFC, carry_out=0, overflow=0. 0x80000000-1 -> out=0x7FFFFFFF, carry_out=1, overflow=1.
- Backpressure: stream 6 beats while holding out_ready=0 for 3 cycles once the first result is valid -> in_ready=0 during the stall, out stays stable, all 6 results arrive in order, none dropped or duplicated.
- Reset mid-flight: assert rst_n=0 asynchronously (between edges) with 3 beats in flight -> out_valid falls to 0 immediately. After release, no stale result emerges, and a new beat 1+1 returns 2 after 4 edges.
- Parameter sweep: STAGES=1, 2 and 32 with WIDTH=32, randomised 1000 beats against a reference model -> all out, carry_out and overflow match, and latency equals STAGES.
